// File: rtl/pic_aux_io_regs.sv
// Aux-bus register block for the PIC14 core: LED latch, debounced pushbuttons, sticky press flags, IRQ.
// Optional 16-bit prescaled timer at offsets 3..5 is built only when PIC_AUX_TIMER_EN is defined.
module pic_aux_io_regs #(
    parameter logic [15:0] BASE_ADDR       = 16'h0000,
    parameter int unsigned NUM_PB          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 5000,
    parameter int unsigned PRESCALE        = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [15:0]       aux_adr_i,
    input  logic [7:0]        aux_dat_i,
    input  logic              aux_we_i,
    input  logic              aux_re_i,
    output logic [7:0]        aux_dat_o,
    output logic              aux_dat_oe,
    input  logic [NUM_PB-1:0] pb_n_i,
    output logic [7:0]        led_o,
    output logic              irq_o
);

    localparam int unsigned    DW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [15:0]       offset;
    logic              hit;
    logic [2:0]        off;
    logic              wr;
    logic [7:0]        rd_data;

    logic [NUM_PB-1:0] pb_meta;
    logic [NUM_PB-1:0] pb_sync;
    logic [NUM_PB-1:0] pb_deb;
    logic [NUM_PB-1:0] pb_deb_next;
    logic [NUM_PB-1:0] pb_rise;
    logic [NUM_PB-1:0] pb_edge;
    logic [NUM_PB-1:0] pb_w1c;
    logic [DW-1:0]     db_cnt [NUM_PB];
    logic [7:0]        pb_state8;
    logic [7:0]        pb_edge8;

    logic [7:0]        tmr_lo_rd;
    logic [7:0]        tmr_hi_rd;
    logic [7:0]        tmr_ctrl_rd;
    logic              tmr_irq;

    // Modular subtraction keeps the decode correct for any BASE_ADDR, including near 16'hFFFF.
    assign offset = aux_adr_i - BASE_ADDR;
    assign hit    = (offset < 16'd6);
    assign off    = offset[2:0];
    assign wr     = aux_we_i & hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_o <= '0;
        end else if (wr && off == 3'd0) begin
            led_o <= aux_dat_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_meta <= '0;
            pb_sync <= '0;
        end else begin
            pb_meta <= ~pb_n_i;
            pb_sync <= pb_meta;
        end
    end

    // A bit is accepted after DEBOUNCE_CYCLES consecutive clocks of disagreement with the debounced value.
    always_comb begin
        pb_deb_next = pb_deb;
        for (int unsigned i = 0; i < NUM_PB; i++) begin
            if (pb_sync[i] != pb_deb[i] && db_cnt[i] == DB_LAST) begin
                pb_deb_next[i] = pb_sync[i];
            end
        end
    end

    assign pb_rise = pb_deb_next & ~pb_deb;
    assign pb_w1c  = (wr && off == 3'd2) ? aux_dat_i[NUM_PB-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_deb  <= '0;
            pb_edge <= '0;
            for (int unsigned i = 0; i < NUM_PB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            pb_deb  <= pb_deb_next;
            pb_edge <= (pb_edge & ~pb_w1c) | pb_rise;
            for (int unsigned i = 0; i < NUM_PB; i++) begin
                if (pb_sync[i] == pb_deb[i] || db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pb_state8 = '0;
        pb_edge8  = '0;
        pb_state8[NUM_PB-1:0] = pb_deb;
        pb_edge8[NUM_PB-1:0]  = pb_edge;
    end

`ifdef PIC_AUX_TIMER_EN
    localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic [15:0]   timer;
    logic [7:0]    tmr_snap;
    logic          tmr_en;
    logic          tmr_mask;
    logic          tmr_ovf;
    logic          re_q;
    logic          ctrl_wr;
    logic          tmr_clr;
    logic          tick;

    assign ctrl_wr = wr && off == 3'd5;
    assign tmr_clr = ctrl_wr && aux_dat_i[1];
    assign tick    = tmr_en && presc == PRE_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc    <= '0;
            timer    <= '0;
            tmr_snap <= '0;
            tmr_en   <= 1'b0;
            tmr_mask <= 1'b0;
            tmr_ovf  <= 1'b0;
            re_q     <= 1'b0;
        end else begin
            re_q <= aux_re_i;
            if (aux_re_i && !re_q && hit && off == 3'd3) begin
                tmr_snap <= timer[15:8];
            end
            if (ctrl_wr) begin
                tmr_en   <= aux_dat_i[0];
                tmr_mask <= aux_dat_i[6];
            end
            if (tmr_clr) begin
                presc <= '0;
                timer <= '0;
            end else if (tmr_en) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    timer <= timer + 16'd1;
                end
            end
            // Overflow set outranks a same-cycle W1C; a clear write suppresses the wrap entirely.
            if (tick && !tmr_clr && timer == 16'hFFFF) begin
                tmr_ovf <= 1'b1;
            end else if (ctrl_wr && aux_dat_i[7]) begin
                tmr_ovf <= 1'b0;
            end
        end
    end

    assign tmr_lo_rd   = timer[7:0];
    assign tmr_hi_rd   = tmr_snap;
    assign tmr_ctrl_rd = {tmr_ovf, tmr_mask, 5'b00000, tmr_en};
    assign tmr_irq     = tmr_ovf & tmr_mask;
`else
    assign tmr_lo_rd   = 8'h00;
    assign tmr_hi_rd   = 8'h00;
    assign tmr_ctrl_rd = 8'h00;
    assign tmr_irq     = 1'b0;
`endif

    always_comb begin
        rd_data = 8'h00;
        case (off)
            3'd0:    rd_data = led_o;
            3'd1:    rd_data = pb_state8;
            3'd2:    rd_data = pb_edge8;
            3'd3:    rd_data = tmr_lo_rd;
            3'd4:    rd_data = tmr_hi_rd;
            3'd5:    rd_data = tmr_ctrl_rd;
            default: rd_data = 8'h00;
        endcase
    end

    assign aux_dat_oe = reset_n & aux_re_i & hit;
    assign aux_dat_o  = aux_dat_oe ? rd_data : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= (|pb_edge) | tmr_irq;
        end
    end

endmodule

// File: tb/tb_pic_aux_io_regs.sv
// Bench for pic_aux_io_regs: directed steps plus random bus/pushbutton traffic against a cycle model.
// Timer checks follow PIC_AUX_TIMER_EN in the same way as the design.
module tb_pic_aux_io_regs;

    localparam logic [15:0] BASE = 16'h0040;
    localparam int          NPB  = 4;
    localparam int          DEB  = 8;
    localparam int          PRE  = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] aux_adr;
    logic [7:0]  aux_wdat;
    logic        aux_we;
    logic        aux_re;
    logic [7:0]  aux_rdat;
    logic        aux_oe;
    logic [3:0]  pb_n;
    logic [7:0]  led;
    logic        irq;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_led;
    logic [3:0]  m_s1, m_s2, m_deb, m_edge;
    int          m_run [NPB];
    logic        m_irq;
    logic [15:0] m_timer;
    int          m_pres;
    logic        m_en, m_mask, m_ovf, m_re_prev;
    logic [7:0]  m_snap;

    pic_aux_io_regs #(
        .BASE_ADDR      (BASE),
        .NUM_PB         (NPB),
        .DEBOUNCE_CYCLES(DEB),
        .PRESCALE       (PRE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .aux_adr_i (aux_adr),
        .aux_dat_i (aux_wdat),
        .aux_we_i  (aux_we),
        .aux_re_i  (aux_re),
        .aux_dat_o (aux_rdat),
        .aux_dat_oe(aux_oe),
        .pb_n_i    (pb_n),
        .led_o     (led),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_led = '0; m_s1 = '0; m_s2 = '0; m_deb = '0; m_edge = '0; m_irq = 1'b0;
        m_timer = '0; m_pres = 0; m_en = 1'b0; m_mask = 1'b0; m_ovf = 1'b0;
        m_re_prev = 1'b0; m_snap = '0;
        for (int i = 0; i < NPB; i++) m_run[i] = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [15:0] a);
        logic [15:0] o;
        o = a - BASE;
        case (o)
            16'd0: return m_led;
            16'd1: return {4'h0, m_deb};
            16'd2: return {4'h0, m_edge};
`ifdef PIC_AUX_TIMER_EN
            16'd3: return m_timer[7:0];
            16'd4: return m_snap;
            16'd5: return {m_ovf, m_mask, 5'b00000, m_en};
`endif
            default: return 8'h00;
        endcase
    endfunction

    // One clock edge of the model; every right-hand side refers to pre-edge state.
    task automatic m_edge_step(input bit we, input bit re, input logic [15:0] a,
                               input logic [7:0] d, input logic [3:0] pbn);
        logic [15:0] o;
        bit          h, wr, wrapped, n_irq;
        logic [3:0]  rose;
        o  = a - BASE;
        h  = (o < 16'd6);
        wr = we && h;
        n_irq = (m_edge != 4'h0);
`ifdef PIC_AUX_TIMER_EN
        n_irq = n_irq || (m_ovf && m_mask);
        if (re && !m_re_prev && h && o == 16'd3) m_snap = m_timer[15:8];
`endif
        m_re_prev = re;
        rose = '0;
        for (int b = 0; b < NPB; b++) begin
            if (m_s2[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_deb[b] = m_s2[b];
                    m_run[b] = 0;
                    rose[b] = m_deb[b];
                end
            end else begin
                m_run[b] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = ~pbn;
        if (wr && o == 16'd2) m_edge = m_edge & ~d[3:0];
        m_edge = m_edge | rose;
`ifdef PIC_AUX_TIMER_EN
        wrapped = 1'b0;
        if (wr && o == 16'd5 && d[1]) begin
            m_pres = 0;
            m_timer = '0;
        end else if (m_en) begin
            m_pres++;
            if (m_pres == PRE) begin
                m_pres = 0;
                m_timer = m_timer + 16'd1;
                wrapped = (m_timer == 16'h0000);
            end
        end
        if (wr && o == 16'd5 && d[7]) m_ovf = 1'b0;
        if (wrapped) m_ovf = 1'b1;
        if (wr && o == 16'd5) begin
            m_en = d[0];
            m_mask = d[6];
        end
`else
        wrapped = 1'b0;
`endif
        if (wr && o == 16'd0) m_led = d;
        m_irq = n_irq;
    endtask

    // One bus cycle: drive on the falling edge, check read path mid-cycle, check registers after the edge.
    task automatic cyc(input bit we, input bit re, input logic [15:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic oe);
        logic [15:0] o;
        bit          h;
        o = a - BASE;
        h = (o < 16'd6);
        @(negedge clk);
        aux_we = we; aux_re = re; aux_adr = a; aux_wdat = d;
        #1;
        rd = aux_rdat;
        oe = aux_oe;
        chk("oe", {7'b0, aux_oe}, {7'b0, re && h});
        chk("rdata", aux_rdat, (re && h) ? m_read(a) : 8'h00);
        @(posedge clk);
        m_edge_step(we, re, a, d, pb_n);
        #1;
        chk("led", led, m_led);
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
    endtask

    task automatic idle(input int n);
        logic [7:0] r;
        logic       e;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 8'h00, r, e);
    endtask

    initial begin
        logic [7:0] rd;
        logic       oe;
        int         hold;

        // Reset state
        reset_n = 1'b0; aux_we = 1'b0; aux_re = 1'b1; aux_adr = BASE; aux_wdat = 8'h00; pb_n = 4'hF;
        m_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_led", led, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_oe", {7'b0, aux_oe}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        aux_re = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, BASE + 16'(i), 8'h00, rd, oe);
            chk("rst_read", rd, 8'h00);
        end

        // LED write/read, out-of-range write, simultaneous write+read
        cyc(1'b1, 1'b0, BASE, 8'hA5, rd, oe);
        chk("led_a5", led, 8'hA5);
        cyc(1'b0, 1'b1, BASE, 8'h00, rd, oe);
        chk("led_rd", rd, 8'hA5);
        chk("led_rd_oe", {7'b0, oe}, 8'h01);
        cyc(1'b1, 1'b1, BASE + 16'd6, 8'h5A, rd, oe);
        chk("oob_oe", {7'b0, oe}, 8'h00);
        chk("oob_led", led, 8'hA5);
        cyc(1'b1, 1'b1, BASE, 8'h3C, rd, oe);
        chk("wr_rd_pre", rd, 8'hA5);
        chk("wr_rd_led", led, 8'h3C);

        // Glitch shorter than the debounce window
        pb_n = 4'b1101;
        idle(5);
        pb_n = 4'b1111;
        idle(20);
        cyc(1'b0, 1'b1, BASE + 16'd1, 8'h00, rd, oe);
        chk("glitch_state", rd, 8'h00);

        // Held press: accepted on the 10th edge
        pb_n = 4'b1101;
        idle(9);
        cyc(1'b0, 1'b1, BASE + 16'd1, 8'h00, rd, oe);
        chk("pb_state_9", rd, 8'h00);
        cyc(1'b0, 1'b1, BASE + 16'd1, 8'h00, rd, oe);
        chk("pb_state_10", rd, 8'h02);
        chk("irq_set", {7'b0, irq}, 8'h01);
        cyc(1'b0, 1'b1, BASE + 16'd2, 8'h00, rd, oe);
        chk("pb_edge_set", rd, 8'h02);
        cyc(1'b1, 1'b0, BASE + 16'd2, 8'h02, rd, oe);
        cyc(1'b0, 1'b1, BASE + 16'd2, 8'h00, rd, oe);
        chk("pb_edge_w1c", rd, 8'h00);
        chk("irq_clr", {7'b0, irq}, 8'h00);
        pb_n = 4'b1111;
        idle(12);
        cyc(1'b0, 1'b1, BASE + 16'd2, 8'h00, rd, oe);
        chk("release_edge", rd, 8'h00);

        // Press detection and W1C on the same edge: the set wins
        pb_n = 4'b1110;
        idle(9);
        cyc(1'b1, 1'b0, BASE + 16'd2, 8'h01, rd, oe);
        cyc(1'b0, 1'b1, BASE + 16'd2, 8'h00, rd, oe);
        chk("collision_edge", rd, 8'h01);
        pb_n = 4'b1111;
        idle(12);
        cyc(1'b1, 1'b0, BASE + 16'd2, 8'h0F, rd, oe);

        // Random bus traffic and bouncing buttons
        hold = 0;
        for (int i = 0; i < 600; i++) begin
            if (hold == 0) begin
                pb_n = 4'($urandom);
                hold = $urandom_range(1, 20);
            end
            hold--;
            cyc(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                BASE - 16'd1 + 16'($urandom_range(0, 8)), 8'($urandom), rd, oe);
        end

        // Asynchronous reset in mid-operation
        @(negedge clk);
        aux_re = 1'b1; aux_adr = BASE; aux_we = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_led", led, 8'h00);
        chk("mid_rst_irq", {7'b0, irq}, 8'h00);
        chk("mid_rst_oe", {7'b0, aux_oe}, 8'h00);
        chk("mid_rst_dat", aux_rdat, 8'h00);
        pb_n = 4'hF;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        aux_re = 1'b0;
        cyc(1'b0, 1'b1, BASE + 16'd0, 8'h00, rd, oe);
        chk("post_rst_led", rd, 8'h00);

`ifdef PIC_AUX_TIMER_EN
        // Full wrap with PRESCALE=1
        cyc(1'b1, 1'b0, BASE + 16'd5, 8'h82, rd, oe);
        cyc(1'b1, 1'b0, BASE + 16'd5, 8'h41, rd, oe);
        idle(65536);
        cyc(1'b0, 1'b1, BASE + 16'd5, 8'h00, rd, oe);
        chk("tmr_ctrl_wrap", rd, 8'hC1);
        chk("tmr_irq", {7'b0, irq}, 8'h01);
        // Snapshot holds the high byte seen at the LO read
        cyc(1'b1, 1'b0, BASE + 16'd5, 8'hC3, rd, oe);
        idle(8'hF0);
        cyc(1'b0, 1'b1, BASE + 16'd3, 8'h00, rd, oe);
        chk("tmr_lo", rd, 8'hF0);
        idle(32);
        cyc(1'b0, 1'b1, BASE + 16'd4, 8'h00, rd, oe);
        chk("tmr_hi_snap", rd, 8'h00);
        cyc(1'b1, 1'b0, BASE + 16'd5, 8'h80, rd, oe);
        cyc(1'b0, 1'b1, BASE + 16'd5, 8'h00, rd, oe);
        chk("tmr_ovf_w1c", rd, 8'h00);
`else
        cyc(1'b1, 1'b0, BASE + 16'd5, 8'hFF, rd, oe);
        cyc(1'b0, 1'b1, BASE + 16'd5, 8'h00, rd, oe);
        chk("no_tmr_ctrl", rd, 8'h00);
        chk("no_tmr_oe", {7'b0, oe}, 8'h01);
        cyc(1'b0, 1'b1, BASE + 16'd3, 8'h00, rd, oe);
        chk("no_tmr_lo", rd, 8'h00);
        idle(20);
        chk("no_tmr_irq", {7'b0, irq}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
